timer_array: RTL

- Multi-channel, bus-mapped down-counter timer peripheral on the CPU's word-addressed peripheral bus, next to the other bridge devices.
- Generalises the single 32-bit timer:
  - NCH independent channels of CW-bit width.
  - Three counting modes.
  - Sticky per-channel pending flags with write-1-to-clear.
  - Fully readable register file.
  - Per-channel and combined interrupt outputs.

---
 rtl/timer_array.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/timer_array.sv
// timer_array: bus-mapped array of NCH down-counting timers, each with a
// programmable preset, three counting modes, a sticky pending flag cleared
// by write-1, and a per-channel interrupt mask. The read data path is
// combinational from the address; all state changes on the rising clock edge.
module timer_array #(
    parameter int NCH = 2,
    parameter int CW  = 32
) (
    input  logic           CLK_I,
    input  logic           RST_I,
    input  logic [5:2]     ADD_I,
    input  logic           WE_I,
    input  logic [31:0]    DAT_I,
    input  logic [3:0]     be,
    output logic [31:0]    DAT_O,
    output logic           IRQ,
    output logic [NCH-1:0] irq_vec
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [1:0]  ch_sel;
    logic [1:0]  reg_sel;
    // Read word of every possible channel slot; unpopulated slots read 0.
    logic [31:0] rd_all [4];

    assign ch_sel  = ADD_I[5:4];
    assign reg_sel = ADD_I[3:2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            if (gi < NCH) begin : g_live
                logic          en_reg;
                logic [1:0]    mode_reg;
                logic          mask_reg;
                logic [CW-1:0] preset_reg;
                logic [CW-1:0] count_reg;
                logic          pend_reg;

                logic          hit;
                logic          ctrl_wr;
                logic          preset_wr;
                logic          stat_clr;
                logic          expire;
                logic [31:0]   preset_ext;
                logic [31:0]   preset_merged;
                logic [CW-1:0] preset_next;
                logic [31:0]   rd_ch;

                // Only populated channels can match, so out-of-range writes fall through.
                assign hit        = WE_I && (ch_sel == 2'(gi));
                assign ctrl_wr    = hit && (reg_sel == REG_CTRL) && be[0];
                assign preset_wr  = hit && (reg_sel == REG_PRESET);
                assign stat_clr   = hit && (reg_sel == REG_STATUS) && be[0] && DAT_I[0];
                assign expire     = en_reg && (count_reg == '0);
                assign preset_ext = 32'(preset_reg);

                // Byte-merge the write data into the current preset; bytes beyond CW drop off.
                always_comb begin
                    preset_merged = preset_ext;
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) begin
                            preset_merged[8*b +: 8] = DAT_I[8*b +: 8];
                        end
                    end
                end
                assign preset_next = preset_merged[CW-1:0];

                // Channel state: register writes, count stepping and expiry handling.
                always_ff @(posedge CLK_I) begin
                    if (RST_I) begin
                        en_reg     <= 1'b0;
                        mode_reg   <= 2'b00;
                        mask_reg   <= 1'b0;
                        preset_reg <= '0;
                        count_reg  <= '0;
                        pend_reg   <= 1'b0;
                    end else begin
                        // Count step uses the control bits as they were before this edge.
                        if (preset_wr) begin
                            preset_reg <= preset_next;
                            count_reg  <= preset_next;
                        end else if (en_reg) begin
                            if (count_reg != '0) begin
                                count_reg <= count_reg - 1'b1;
                            end else begin
                                case (mode_reg)
                                    2'b01:   count_reg <= preset_reg;
                                    2'b10:   count_reg <= '1;
                                    default: count_reg <= '0;
                                endcase
                            end
                        end

                        // A CTRL write beats the one-shot self-disable.
                        if (ctrl_wr) begin
                            en_reg   <= DAT_I[0];
                            mode_reg <= DAT_I[2:1];
                            mask_reg <= DAT_I[3];
                        end else if (expire && (mode_reg == 2'b00 || mode_reg == 2'b11)) begin
                            en_reg <= 1'b0;
                        end

                        // Expiry beats a simultaneous write-1-to-clear.
                        if (expire) begin
                            pend_reg <= 1'b1;
                        end else if (stat_clr) begin
                            pend_reg <= 1'b0;
                        end
                    end
                end

                // Register read mux for this channel.
                always_comb begin
                    rd_ch = '0;
                    case (reg_sel)
                        REG_CTRL:   rd_ch = {28'b0, mask_reg, mode_reg, en_reg};
                        REG_PRESET: rd_ch = 32'(preset_reg);
                        REG_COUNT:  rd_ch = 32'(count_reg);
                        REG_STATUS: rd_ch = {31'b0, pend_reg};
                        default:    rd_ch = '0;
                    endcase
                end

                assign rd_all[gi]  = rd_ch;
                assign irq_vec[gi] = pend_reg & mask_reg;
            end else begin : g_none
                assign rd_all[gi] = '0;
            end
        end
    endgenerate

    assign DAT_O = rd_all[ch_sel];
    assign IRQ   = |irq_vec;

endmodule
